reaction_ctrl: RTL



---
 rtl/reaction_pkg.sv | 19 +
 rtl/reaction_ctrl_unit_prescaler.sv | 29 ++
 rtl/reaction_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer control path.
// State encoding, datapath widths and default timing parameters.
package reaction_pkg;

  localparam int RT_W        = 14;
  localparam int RND_W       = 5;
  localparam int UNIT_MS_D   = 100;
  localparam int MIN_UNITS_D = 10;
  localparam int MAX_RT_MS_D = 9999;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    GO    = 3'd2,
    DONE  = 3'd3,
    EARLY = 3'd4
  } state_t;

endpackage

// File: rtl/reaction_ctrl_unit_prescaler.sv
// Divides the millisecond tick down to one pulse per delay unit.
// Held at zero by clear so every delay starts on a unit boundary.
module unit_prescaler #(
  parameter int UNIT_MS = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick_ms,
  output logic unit_tick
);

  localparam int SW = (UNIT_MS > 1) ? $clog2(UNIT_MS) : 1;
  localparam logic [SW-1:0] LAST = SW'(UNIT_MS - 1);

  logic [SW-1:0] sub;

  assign unit_tick = tick_ms && (sub == LAST);

  // Count ms ticks within the current unit, wrapping on the last one.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sub <= '0;
    end else if (tick_ms) begin
      sub <= unit_tick ? '0 : sub + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction timer control FSM: random pre-delay, GO lamp, and
// millisecond reaction measurement with early/timeout flags.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int UNIT_MS   = UNIT_MS_D,
  parameter int MIN_UNITS = MIN_UNITS_D,
  parameter int MAX_RT_MS = MAX_RT_MS_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_ms,
  input  logic             start,
  input  logic             stop,
  input  logic [RND_W-1:0] rnd,
  output logic             led,
  output logic             busy,
  output logic [RT_W-1:0]  rt_ms,
  output logic             valid,
  output logic             early,
  output logic             timeout
);

  localparam logic [RT_W-1:0] MAX_RT = RT_W'(MAX_RT_MS);

  state_t          state;
  logic [6:0]      units;
  logic [RT_W-1:0] cnt;
  logic            unit_tick;
  logic            clr;

  assign clr = (state != WAIT);

  unit_prescaler #(
    .UNIT_MS (UNIT_MS)
  ) u_pre (
    .clk       (clk),
    .reset     (reset),
    .clear     (clr),
    .tick_ms   (tick_ms),
    .unit_tick (unit_tick)
  );

  // Main FSM with registered Moore outputs and the rt counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      units   <= '0;
      cnt     <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
      rt_ms   <= '0;
      valid   <= 1'b0;
      early   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, EARLY: begin
          if (start) begin
            units   <= 7'(MIN_UNITS) + 7'(rnd);
            valid   <= 1'b0;
            early   <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (stop) begin
            early <= 1'b1;
            busy  <= 1'b0;
            state <= EARLY;
          end else if (unit_tick) begin
            units <= units - 7'd1;
            if (units == 7'd1) begin
              cnt   <= '0;
              led   <= 1'b1;
              state <= GO;
            end
          end
        end
        GO: begin
          if (stop) begin
            rt_ms <= cnt;
            valid <= 1'b1;
            led   <= 1'b0;
            busy  <= 1'b0;
            state <= DONE;
          end else if (tick_ms) begin
            if (cnt == MAX_RT - 1'b1) begin
              cnt     <= MAX_RT;
              rt_ms   <= MAX_RT;
              valid   <= 1'b1;
              timeout <= 1'b1;
              led     <= 1'b0;
              busy    <= 1'b0;
              state   <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          led   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
